// File: rtl/regfile_sb.sv
// Integer register file with write-to-read bypass, per-register busy scoreboard and a
// post-reset clear sequencer that zeroes registers 1..NREGS-1 before the file reports ready.
module regfile_sb #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                ready,
    input  logic                we,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_addr,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    output logic [NREGS-1:0]    busy_vec
);

    if (NREGS < 4 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
        $error("regfile_sb: NREGS must be a power of two and at least 4");
    end
    if (NRD < 1 || NRD > 4) begin : g_bad_nrd
        $error("regfile_sb: NRD must be in 1..4");
    end

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [NREGS-1:0] busy_q, busy_d;
    logic [XLEN-1:0]  regs_q [NREGS];

    logic             run;
    logic             wb_fire;
    logic             issue_fire;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [XLEN-1:0]  mem_wdata;
    logic [AW-1:0]    rd_idx;
    logic             rd_hit;

    assign run        = (state_q == StRun);
    assign ready      = run;
    assign wb_fire    = run && we && (wr_addr != '0);
    assign issue_fire = run && issue_valid && (issue_addr != '0);
    assign busy_vec   = busy_q;

    // Sequencer and the single array write port it shares with writeback.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        case (state_q)
            StClear: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = '0;
                ptr_d     = ptr_q + AW'(1);
                if (ptr_q == AW'(NREGS - 1)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                mem_we = wb_fire;
            end
            default: begin
                state_d = StClear;
            end
        endcase
    end

    // Clear applied first so a same-cycle issue to the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_fire) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (issue_fire) begin
            busy_d[issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StClear;
            ptr_q   <= AW'(1);
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    // Storage is plain memory; the clear sequencer provides the known state.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            regs_q[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        rd_idx  = '0;
        rd_hit  = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            rd_idx = rd_addr[i*AW +: AW];
            rd_hit = we && (wr_addr == rd_idx);
            if (run && rd_idx != '0) begin
                rd_data[i*XLEN +: XLEN] = rd_hit ? wr_data : regs_q[rd_idx];
                rd_busy[i]              = busy_q[rd_idx] && !rd_hit;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised scoreboard bench for regfile_sb: stimulus pushes expectations from a behavioural
// model into a queue, a separate monitor pops and compares them against the DUT outputs.
module tb_regfile_sb;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned AW    = 5;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                ready;
    logic                we = 1'b0;
    logic [AW-1:0]       wr_addr = '0;
    logic [XLEN-1:0]     wr_data = '0;
    logic                issue_valid = 1'b0;
    logic [AW-1:0]       issue_addr = '0;
    logic [NRD*AW-1:0]   rd_addr = '0;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NREGS-1:0]    busy_vec;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ready      (ready),
        .we         (we),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .issue_valid(issue_valid),
        .issue_addr (issue_addr),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .busy_vec   (busy_vec)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NRD*XLEN-1:0] rd;
        logic [NRD-1:0]      rb;
        logic [NREGS-1:0]    bv;
        logic                rdy;
    } exp_t;

    exp_t            exp_q[$];
    int              n_vec = 0;
    int              n_bad = 0;
    event            chk_ev;

    // Reference model: architectural contents, pending producers, edges left in the clear.
    logic [XLEN-1:0] m_regs [NREGS];
    logic [NREGS-1:0] m_busy;
    int              clear_left;

    task automatic check(input string name, input int idx, input logic [63:0] got,
                         input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s[%0d] at %0t: got %h, expected %h", name, idx, $time, got, want);
        end
    endtask

    function automatic void model_reset();
        clear_left = NREGS - 1;
        m_busy     = '0;
    endfunction

    function automatic void model_edge();
        if (!rst_n) return;
        if (clear_left > 0) begin
            clear_left--;
            if (clear_left == 0) begin
                for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
            end
        end else begin
            if (we && wr_addr != 0) begin
                m_regs[wr_addr] = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (issue_valid && issue_addr != 0) m_busy[issue_addr] = 1'b1;
        end
    endfunction

    function automatic exp_t expect_now();
        exp_t          e;
        logic [AW-1:0] a;
        e.rd  = '0;
        e.rb  = '0;
        e.bv  = m_busy;
        e.rdy = (clear_left == 0);
        if (clear_left == 0) begin
            for (int p = 0; p < NRD; p++) begin
                a = rd_addr[p*AW +: AW];
                if (a != 0) begin
                    e.rd[p*XLEN +: XLEN] = (we && wr_addr == a) ? wr_data : m_regs[a];
                    e.rb[p] = m_busy[a] && !(we && wr_addr == a);
                end
            end
        end
        return e;
    endfunction

    // Monitor: compares whenever an expectation is pending at the sampling point.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or chk_ev);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int p = 0; p < NRD; p++) begin
                    check("rd_data", p, 64'(rd_data[p*XLEN +: XLEN]), 64'(e.rd[p*XLEN +: XLEN]));
                    check("rd_busy", p, 64'(rd_busy[p]), 64'(e.rb[p]));
                end
                check("busy_vec", 0, 64'(busy_vec), 64'(e.bv));
                check("ready", 0, 64'(ready), 64'(e.rdy));
            end
        end
    end

    function automatic logic [NRD*AW-1:0] pk(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        return {a1, a0};
    endfunction

    task automatic step(input logic w, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                        input logic iv, input logic [AW-1:0] ia, input logic [NRD*AW-1:0] ra);
        @(posedge clk);
        model_edge();
        #1;
        we          = w;
        wr_addr     = wa;
        wr_data     = wd;
        issue_valid = iv;
        issue_addr  = ia;
        rd_addr     = ra;
        exp_q.push_back(expect_now());
    endtask

    task automatic idle(input logic [NRD*AW-1:0] ra);
        step(1'b0, '0, '0, 1'b0, '0, ra);
    endtask

    function automatic logic [AW-1:0] raddr();
        return AW'($urandom_range(NREGS - 1));
    endfunction

    // Random traffic; during a clear it must be ignored by the DUT.
    task automatic rand_step();
        logic [AW-1:0] wa;
        logic [AW-1:0] ia;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        wa = ($urandom_range(1) == 1) ? AW'($urandom_range(7)) : raddr();
        ia = ($urandom_range(1) == 1) ? AW'($urandom_range(7)) : raddr();
        a0 = ($urandom_range(1) == 1) ? wa : raddr();
        a1 = ($urandom_range(2) == 0) ? ia : AW'($urandom_range(7));
        step(1'($urandom_range(1)), wa, $urandom, 1'($urandom_range(9) < 4), ia, pk(a0, a1));
    endtask

    task automatic reset_pulse(input int hold);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        repeat (hold) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Asserts reset between edges and checks the outputs before any clock edge arrives.
    task automatic async_reset_check(input int hold);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        exp_q.push_back(expect_now());
        ->chk_ev;
        repeat (hold) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NREGS; i++) idle(pk(raddr(), raddr()));

        for (int r = 1; r < NREGS; r++) step(1'b1, AW'(r), '1, 1'b0, '0, pk(AW'(r), raddr()));
        idle(pk(5'd3, 5'd31));

        // Clear after the file was full of ones: reads stay zero, ready after 31 edges.
        reset_pulse(2);
        for (int i = 0; i < NREGS + 1; i++) rand_step();
        for (int r = 1; r < NREGS; r += 2) idle(pk(AW'(r), AW'(r + 1)));

        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, pk(5'd5, 5'd5));
        idle(pk(5'd5, 5'd5));

        step(1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, pk(5'd0, 5'd0));
        idle(pk(5'd0, 5'd5));

        step(1'b0, '0, '0, 1'b1, 5'd7, pk(5'd7, 5'd1));
        idle(pk(5'd7, 5'd7));
        step(1'b1, 5'd7, 32'h0000_0707, 1'b0, '0, pk(5'd7, 5'd2));
        idle(pk(5'd7, 5'd7));

        for (int r = 4; r < 8; r++) step(1'b0, '0, '0, 1'b1, AW'(r), pk(AW'(r), 5'd0));
        idle(pk(5'd4, 5'd7));
        async_reset_check(2);
        for (int i = 0; i < NREGS; i++) idle(pk(5'd4, 5'd7));

        step(1'b0, '0, '0, 1'b1, 5'd9, pk(5'd9, 5'd0));
        step(1'b1, 5'd9, 32'h55, 1'b1, 5'd9, pk(5'd9, 5'd9));
        idle(pk(5'd9, 5'd9));
        step(1'b1, 5'd9, 32'h66, 1'b1, 5'd10, pk(5'd9, 5'd10));
        idle(pk(5'd9, 5'd10));

        reset_pulse(2);
        for (int i = 0; i < 9; i++) rand_step();
        async_reset_check(2);
        for (int i = 0; i < NREGS; i++) rand_step();

        for (int i = 0; i < 400; i++) rand_step();

        @(negedge clk);
        #1;
        check("queue_drained", 0, 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with configurable width, depth and read-port count. Adds three things to a plain register file: write-to-read bypass, a per-register busy scoreboard, and a hardware clear sequencer that zeroes every register after reset. It sits between decode/issue and writeback in the core. Register 0 is hardwired to zero.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥ 4); AW = $clog2(NREGS)
- NRD, 2, number of read ports (1..4)
- clk  in  1  single clock, rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- ready  out  1  high once the clear sequence has completed
- we  in  1  writeback valid
- wr_addr  in  AW  writeback register index
- wr_data  in  XLEN  writeback data
- issue_valid  in  1  an instruction with destination issue_addr is issued this cycle
- issue_addr  in  AW  destination register of the issued instruction
- rd_addr  in  NRD*AW  read indices, port i at bits [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data, port i at bits [i*XLEN +: XLEN]
- rd_busy  out  NRD  port i reads a register with a pending producer
- busy_vec  out  NREGS  full scoreboard; bit 0 is always 0

## Operation
- States: CLEAR and RUN. The state register is a flop with asynchronous reset.
- **While rst_n = 0**
  - State = CLEAR, clear pointer = 1.
  - busy_vec = 0, ready = 0.
  - Register storage is not reset. It is plain memory.
- **CLEAR state**
  - Each rising edge writes 0 to regs[ptr], then ptr increments.
  - On the edge where ptr = NREGS-1, the sequencer writes that register and moves to RUN.
  - we and issue_valid are ignored.
  - rd_data = 0 and rd_busy = 0 on all ports.
- **RUN, write**
  - When we = 1 and wr_addr ≠ 0, regs[wr_addr] ← wr_data at the edge.
  - A write to index 0 is dropped.
- **RUN, read** (combinational, per port i)
  - If rd_addr_i = 0, rd_data_i = 0.
  - Else if we = 1 and wr_addr = rd_addr_i, rd_data_i = wr_data (bypass, write-first).
  - Else rd_data_i = regs[rd_addr_i].
- **RUN, scoreboard**
  - At the edge, busy[issue_addr] is set when issue_valid = 1 and issue_addr ≠ 0.
  - At the edge, busy[wr_addr] is cleared when we = 1 and wr_addr ≠ 0.
  - If both events name the same address in the same cycle, set wins: a new producer supersedes the one writing back.
  - Events on different addresses are independent.
- **rd_busy_i**
  - rd_busy_i = busy[rd_addr_i] AND NOT (we AND wr_addr = rd_addr_i AND rd_addr_i ≠ 0).
  - In words: a writeback in the same cycle satisfies the dependency through the bypass.
- **Other rules**
  - Duplicate issue to an already-busy register leaves it busy. No error is flagged.
  - A writeback to a non-busy register is legal and writes the data.
  - All read ports are independent and may alias.

## Timing
- Read path and rd_busy are zero-latency combinational from rd_addr, we, wr_addr, wr_data and state.
- A write is visible through the array on the cycle after the edge. In the same cycle it is visible only through the bypass.
- A busy set or clear is visible on busy_vec and rd_busy the cycle after the edge.
- ready goes high after exactly NREGS-1 rising edges with rst_n = 1 (31 edges at the defaults).
- Reset asserted mid-CLEAR or mid-RUN:
  - State, pointer, busy_vec and ready return to reset values immediately, without waiting for clk.
  - The clear sequence restarts at index 1 after deassertion.
- Reset deassertion must be synchronised externally to clk. The block does no internal synchronisation.

## Test plan
- **Reset and clear:** fill regs 1..31 with 0xFFFFFFFF, pulse rst_n low for 2 cycles, release.
  - ready = 0 for 31 edges, then 1.
  - All reads return 0, and busy_vec = 0 throughout.
- **Bypass:** in RUN, hold we = 1, wr_addr = 5, wr_data = 0xDEADBEEF, rd_addr0 = 5, rd_addr1 = 5 in the same cycle.
  - Both rd_data = 0xDEADBEEF in that cycle.
  - The next cycle, with we = 0, both still read 0xDEADBEEF.
- **x0:** we = 1, wr_addr = 0, wr_data = 0x12345678, and issue_valid = 1, issue_addr = 0.
  - rd_data for addr 0 is 0 in the same cycle and in later cycles.
  - busy_vec[0] stays 0.
- **Scoreboard:** issue to register 7.
  - The next cycle busy_vec[7] = 1 and rd_busy = 1 for rd_addr = 7.
  - In the writeback cycle (we, wr_addr = 7) rd_busy = 0 combinationally.
  - After that edge busy_vec[7] = 0.
- **Set-wins:** same cycle, issue_valid with issue_addr = 9 and we with wr_addr = 9, data 0x55, register 9 already busy.
  - After the edge busy_vec[9] = 1 and regs[9] reads 0x55.
- **Reset mid-clear and mid-RUN:**
  - Assert rst_n low at the 10th clear edge: ready stays 0 and a full 31-edge clear follows release.
  - Assert rst_n low with busy_vec = 0x000000F0 in RUN: busy_vec = 0 before the next clk edge.
